// File: rtl/bht_2bit_predictor_if.sv
// Signal bundle between the core pipeline (master) and the branch predictor (slave):
// IF-stage lookup plus EX-stage resolve/redirect.
interface bht_2bit_predictor_if;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_target;
    logic        i_ex_vld;
    logic        i_ex_is_br;
    logic        i_ex_is_jmp;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_target;
    logic        o_redirect;
    logic [31:0] o_redirect_pc;
    logic        o_ctrl;
    logic        o_mispred;

    modport master (
        output i_if_pc, i_ex_vld, i_ex_is_br, i_ex_is_jmp, i_ex_pc, i_ex_taken,
               i_ex_target, i_ex_pred_taken, i_ex_pred_target,
        input  o_pred_taken, o_pred_target, o_redirect, o_redirect_pc, o_ctrl, o_mispred
    );

    modport slave (
        input  i_if_pc, i_ex_vld, i_ex_is_br, i_ex_is_jmp, i_ex_pc, i_ex_taken,
               i_ex_target, i_ex_pred_taken, i_ex_pred_target,
        output o_pred_taken, o_pred_target, o_redirect, o_redirect_pc, o_ctrl, o_mispred
    );
endinterface

// File: rtl/bht_2bit_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: zero-latency IF lookup, EX resolve/train.
// Optional gshare counter indexing is enabled by defining BP_GSHARE_EN.
module bht_2bit_predictor #(
    parameter int IDX_BITS = 6
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    bht_2bit_predictor_if.slave  bus
);
    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    logic                valid  [ENTRIES];
    logic [TAG_BITS-1:0] tag    [ENTRIES];
    logic [31:0]         target [ENTRIES];
    logic                jmp    [ENTRIES];
    logic [1:0]          ctr    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx;
    logic [IDX_BITS-1:0] ex_idx;
    logic [IDX_BITS-1:0] if_cidx;
    logic [IDX_BITS-1:0] ex_cidx;
    logic [TAG_BITS-1:0] if_tag;
    logic [TAG_BITS-1:0] ex_tag;
    logic                if_hit;
    logic                ex_hit;
    logic                pred_taken;
    logic                ctrl;
    logic                wrong;
    logic                mispred;
    logic                alias_redir;

    assign if_idx = bus.i_if_pc[IDX_BITS+1:2];
    assign if_tag = bus.i_if_pc[31:IDX_BITS+2];
    assign ex_idx = bus.i_ex_pc[IDX_BITS+1:2];
    assign ex_tag = bus.i_ex_pc[31:IDX_BITS+2];

`ifdef BP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr;

    // History is not checkpointed: EX indexes with whatever GHR holds at resolve time.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            ghr <= '0;
        end else if (ctrl && bus.i_ex_is_br) begin
            ghr <= {ghr[IDX_BITS-2:0], bus.i_ex_taken};
        end
    end

    assign if_cidx = if_idx ^ ghr;
    assign ex_cidx = ex_idx ^ ghr;
`else
    assign if_cidx = if_idx;
    assign ex_cidx = ex_idx;
`endif

    assign if_hit = valid[if_idx] && (tag[if_idx] == if_tag);
    assign ex_hit = valid[ex_idx] && (tag[ex_idx] == ex_tag);

    assign pred_taken         = i_reset && if_hit && (jmp[if_idx] || ctr[if_cidx][1]);
    assign bus.o_pred_taken   = pred_taken;
    assign bus.o_pred_target  = pred_taken ? target[if_idx] : bus.i_if_pc + 32'd4;

    assign ctrl        = bus.i_ex_vld && (bus.i_ex_is_br || bus.i_ex_is_jmp);
    assign wrong       = (bus.i_ex_pred_taken != bus.i_ex_taken) ||
                         (bus.i_ex_taken && (bus.i_ex_pred_target != bus.i_ex_target));
    assign mispred     = ctrl && wrong;
    // A non-control insn predicted taken means the BTB entry aliased onto it.
    assign alias_redir = bus.i_ex_vld && !(bus.i_ex_is_br || bus.i_ex_is_jmp) && bus.i_ex_pred_taken;

    assign bus.o_ctrl        = i_reset && ctrl;
    assign bus.o_mispred     = i_reset && mispred;
    assign bus.o_redirect    = i_reset && (mispred || alias_redir);
    assign bus.o_redirect_pc = !bus.i_ex_vld   ? 32'd0 :
                               bus.i_ex_taken  ? bus.i_ex_target : bus.i_ex_pc + 32'd4;

    // Training happens at the EX-stage entry; the IF lookup above sees pre-update contents.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid[i] <= 1'b0;
                ctr[i]   <= 2'b01;
            end
        end else if (ctrl) begin
            if (ex_hit) begin
                if (bus.i_ex_taken) begin
                    if (ctr[ex_cidx] != 2'b11) begin
                        ctr[ex_cidx] <= ctr[ex_cidx] + 2'd1;
                    end
                    target[ex_idx] <= bus.i_ex_target;
                end else if (ctr[ex_cidx] != 2'b00) begin
                    ctr[ex_cidx] <= ctr[ex_cidx] - 2'd1;
                end
            end else if (bus.i_ex_taken) begin
                valid[ex_idx]  <= 1'b1;
                tag[ex_idx]    <= ex_tag;
                target[ex_idx] <= bus.i_ex_target;
                jmp[ex_idx]    <= bus.i_ex_is_jmp;
                ctr[ex_cidx]   <= 2'b10;
            end
        end else if (alias_redir && ex_hit) begin
            valid[ex_idx] <= 1'b0;
        end
    end
endmodule
